sha_msg_server: RTL and testbench

Bus responder that serves 32-bit message-schedule words to the SHA-256 compression core over its rq/rdy/addr/data word-fetch interface. It holds the 80-byte block header, a nonce register and a 256-bit first-pass digest. From these it produces the three 512-bit chunks a double-SHA miner needs: header chunk 0, header chunk 1 with nonce and padding, and the padded digest for the second pass. It sits between the host-side register file and the compression core.

---
 rtl/sha_msg_server.sv | 128 ++++++++++++
 tb/tb_sha_msg_server.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_server.sv
// Word server for the SHA-256 core: header chunks 0/1 and the padded second-pass digest chunk.
// Request accepted in IDLE, rdy pulses LATENCY+1 cycles later; dropping rq while waiting aborts.
module sha_msg_server #(
   parameter int LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rq,
   input  logic [3:0]   addr,
   output logic         rdy,
   output logic [31:0]  data,
   input  logic [1:0]   mode,
   input  logic         hdr_we,
   input  logic [4:0]   hdr_idx,
   input  logic [31:0]  hdr_wdata,
   input  logic         nonce_ld,
   input  logic [31:0]  nonce_in,
   input  logic         nonce_inc,
   output logic [31:0]  nonce,
   input  logic         dig_we,
   input  logic [255:0] dig_in,
   output logic         busy,
   output logic         blk_served
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LAT = 4'(LATENCY);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    a_q, a_d;
   logic [1:0]    m_q, m_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   nonce_q, nonce_d;
   logic [255:0]  dig_q, dig_d;
   logic [31:0]   hdr_q [19];
   logic [31:0]   hdr_d [19];
   logic [31:0]   word;

   // Word selection uses the registered request and the storage as it stands before this edge.
   always_comb begin
      word = '0;
      case (m_q)
         2'd0: word = hdr_q[{1'b0, a_q}];
         2'd1: begin
            if (a_q < 4'd3)       word = hdr_q[5'd16 + {3'b000, a_q[1:0]}];
            else if (a_q == 4'd3) word = nonce_q;
            else if (a_q == 4'd4) word = 32'h8000_0000;
            else if (a_q == 4'd15) word = 32'h0000_0280;
         end
         2'd2: begin
            if (!a_q[3])          word = dig_q[{~a_q[2:0], 5'b00000} +: 32];
            else if (a_q == 4'd8) word = 32'h8000_0000;
            else if (a_q == 4'd15) word = 32'h0000_0100;
         end
         default: word = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      m_d     = m_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (rq) begin
               a_d     = addr;
               m_d     = mode;
               cnt_d   = LAT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!rq) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               data_d  = word;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hdr_d = hdr_q;
      if (hdr_we && (hdr_idx < 5'd19)) hdr_d[hdr_idx] = hdr_wdata;
      dig_d = dig_we ? dig_in : dig_q;
      if (nonce_ld)       nonce_d = nonce_in;
      else if (nonce_inc) nonce_d = nonce_q + 32'd1;
      else                nonce_d = nonce_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         m_q     <= '0;
         data_q  <= '0;
         nonce_q <= '0;
         dig_q   <= '0;
         hdr_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         m_q     <= m_d;
         data_q  <= data_d;
         nonce_q <= nonce_d;
         dig_q   <= dig_d;
         hdr_q   <= hdr_d;
      end
   end

   assign rdy        = (state_q == S_RESP);
   assign busy       = (state_q != S_IDLE);
   assign blk_served = rdy && (a_q == 4'd15);
   assign data       = data_q;
   assign nonce      = nonce_q;

endmodule

// File: tb/tb_sha_msg_server.sv
// Directed bench for sha_msg_server: all three chunks, nonce rules, latency, abort and async reset.
module tb_sha_msg_server;

   logic         clk;
   logic         rst_n;
   logic         rq1, rq3;
   logic [3:0]   addr;
   logic [1:0]   mode;
   logic         hdr_we;
   logic [4:0]   hdr_idx;
   logic [31:0]  hdr_wdata;
   logic         nonce_ld;
   logic [31:0]  nonce_in;
   logic         nonce_inc;
   logic         dig_we;
   logic [255:0] dig_in;

   logic         rdy1, busy1, blk1, rdy3, busy3, blk3;
   logic [31:0]  data1, nonce1, data3, nonce3;

   int n_cmp;
   int n_bad;

   sha_msg_server #(.LATENCY(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .rq(rq1), .addr(addr), .rdy(rdy1), .data(data1),
      .mode(mode), .hdr_we(hdr_we), .hdr_idx(hdr_idx), .hdr_wdata(hdr_wdata),
      .nonce_ld(nonce_ld), .nonce_in(nonce_in), .nonce_inc(nonce_inc), .nonce(nonce1),
      .dig_we(dig_we), .dig_in(dig_in), .busy(busy1), .blk_served(blk1)
   );

   sha_msg_server #(.LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .rq(rq3), .addr(addr), .rdy(rdy3), .data(data3),
      .mode(mode), .hdr_we(hdr_we), .hdr_idx(hdr_idx), .hdr_wdata(hdr_wdata),
      .nonce_ld(nonce_ld), .nonce_in(nonce_in), .nonce_inc(nonce_inc), .nonce(nonce3),
      .dig_we(dig_we), .dig_in(dig_in), .busy(busy3), .blk_served(blk3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic hdr_wr(input logic [4:0] idx, input logic [31:0] val);
      hdr_we = 1'b1; hdr_idx = idx; hdr_wdata = val;
      @(posedge clk); #1;
      hdr_we = 1'b0;
   endtask

   // Called and returns at 1ns after a rising edge; lat counts edges from raising rq to seeing rdy.
   task automatic fetch(input bit use3, input logic [3:0] a, output logic [31:0] d,
                        output int lat, output logic blk);
      bit seen;
      seen = 1'b0; lat = 0; d = '0; blk = 1'b0;
      addr = a;
      if (use3) rq3 = 1'b1; else rq1 = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (use3 ? rdy3 : rdy1) begin
            seen = 1'b1;
            d    = use3 ? data3 : data1;
            blk  = use3 ? blk3 : blk1;
         end
      end
      rq1 = 1'b0; rq3 = 1'b0;
      if (!seen) chk("fetch_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      chk("rdy_one_cycle", {31'd0, use3 ? rdy3 : rdy1}, 32'd0);
   endtask

   function automatic logic [31:0] exp_m1(input int a);
      case (a)
         0:       return 32'hAAAA0000;
         1:       return 32'hBBBB0000;
         2:       return 32'hCCCC0000;
         3:       return 32'h12345678;
         4:       return 32'h80000000;
         15:      return 32'h00000280;
         default: return 32'h00000000;
      endcase
   endfunction

   function automatic logic [31:0] exp_m2(input int a);
      if (a < 8)   return 32'(a);
      if (a == 8)  return 32'h80000000;
      if (a == 15) return 32'h00000100;
      return 32'h00000000;
   endfunction

   initial begin
      logic [31:0] d;
      logic        blk;
      int          lat;
      int          blk_cnt;
      bit          saw_rdy;

      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; rq1 = 1'b0; rq3 = 1'b0; addr = '0; mode = '0;
      hdr_we = 1'b0; hdr_idx = '0; hdr_wdata = '0;
      nonce_ld = 1'b0; nonce_in = '0; nonce_inc = 1'b0;
      dig_we = 1'b0; dig_in = '0;

      #12;
      chk("rst_rdy",   {31'd0, rdy1}, 32'd0);
      chk("rst_data",  data1, 32'd0);
      chk("rst_busy",  {31'd0, busy1}, 32'd0);
      chk("rst_blk",   {31'd0, blk1}, 32'd0);
      chk("rst_nonce", nonce1, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // header chunk 0
      for (int i = 0; i < 16; i++) hdr_wr(5'(i), 32'h01010101 * (i + 1));
      mode = 2'd0;
      blk_cnt = 0;
      for (int a = 0; a < 16; a++) begin
         fetch(1'b0, 4'(a), d, lat, blk);
         chk($sformatf("m0_w%0d", a), d, 32'h01010101 * (a + 1));
         if (blk) blk_cnt++;
         if (a == 0)  chk("lat1", 32'(lat), 32'd3);
         if (a == 15) chk("m0_blk_on_w15", {31'd0, blk}, 32'd1);
      end
      chk("m0_blk_count", 32'(blk_cnt), 32'd1);

      // header chunk 1
      hdr_wr(5'd16, 32'hAAAA0000);
      hdr_wr(5'd17, 32'hBBBB0000);
      hdr_wr(5'd18, 32'hCCCC0000);
      nonce_ld = 1'b1; nonce_in = 32'h12345678;
      @(posedge clk); #1;
      nonce_ld = 1'b0;
      chk("nonce_ld", nonce1, 32'h12345678);
      mode = 2'd1;
      for (int a = 0; a < 16; a++) begin
         fetch(1'b0, 4'(a), d, lat, blk);
         chk($sformatf("m1_w%0d", a), d, exp_m1(a));
      end

      // digest chunk
      dig_in = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
      dig_we = 1'b1;
      @(posedge clk); #1;
      dig_we = 1'b0;
      mode = 2'd2;
      blk_cnt = 0;
      for (int a = 0; a < 16; a++) begin
         fetch(1'b0, 4'(a), d, lat, blk);
         chk($sformatf("m2_w%0d", a), d, exp_m2(a));
         if (blk) blk_cnt++;
      end
      chk("m2_blk_count", 32'(blk_cnt), 32'd1);

      // nonce wrap and load priority
      nonce_ld = 1'b1; nonce_in = 32'hFFFFFFFE;
      @(posedge clk); #1;
      nonce_ld = 1'b0; nonce_inc = 1'b1;
      @(posedge clk); #1;
      chk("nonce_inc1", nonce1, 32'hFFFFFFFF);
      @(posedge clk); #1;
      nonce_inc = 1'b0;
      chk("nonce_wrap", nonce1, 32'h00000000);
      nonce_ld = 1'b1; nonce_inc = 1'b1; nonce_in = 32'd5;
      @(posedge clk); #1;
      nonce_ld = 1'b0; nonce_inc = 1'b0;
      chk("nonce_ld_prio", nonce1, 32'd5);

      // LATENCY=3 instance: one more edge of WAIT per extra latency cycle
      mode = 2'd0;
      fetch(1'b1, 4'd0, d, lat, blk);
      chk("lat3", 32'(lat), 32'd5);
      chk("lat3_data", d, 32'h01010101);

      // abort while waiting
      addr = 4'd1; rq3 = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy_wait", {31'd0, busy3}, 32'd1);
      @(posedge clk); #1;
      rq3 = 1'b0;
      saw_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rdy3) saw_rdy = 1'b1;
      end
      chk("abort_no_rdy", {31'd0, saw_rdy}, 32'd0);
      chk("abort_idle", {31'd0, busy3}, 32'd0);

      // reserved mode, then a non-zero word so the reset check below is meaningful
      mode = 2'd3;
      fetch(1'b0, 4'd4, d, lat, blk);
      chk("m3_zero", d, 32'd0);
      mode = 2'd0;
      fetch(1'b0, 4'd5, d, lat, blk);
      chk("m0_w5_again", d, 32'h06060606);

      // async reset while waiting
      addr = 4'd2; rq1 = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_rdy",  {31'd0, rdy1}, 32'd0);
      chk("arst_data", data1, 32'd0);
      chk("arst_busy", {31'd0, busy1}, 32'd0);
      rq1 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_nonce", nonce1, 32'd0);
      hdr_wr(5'd2, 32'hDEADBEEF);
      fetch(1'b0, 4'd2, d, lat, blk);
      chk("post_rst_w2", d, 32'hDEADBEEF);
      chk("post_rst_lat", 32'(lat), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
